rrf_alloc_ctrl: RTL and testbench
=================================

# rrf_alloc_ctrl

Free-list controller for the rename register file (RRF) behind the dual-issue decoder. Each cycle it grants up to two RRF tags to the A/B decode slots, which request them with their map enables. It also returns up to two tags per cycle from retire, and raises the per-slot rename errors that stall Fetch/Decode and bubble Decode/Dispatch. On reset or pipeline flush it rebuilds the free list itself, one entry per cycle.

## Interface
- RRF_DEPTH, 16, number of RRF entries (power of two, ≥4)
- TAG_W, 4, tag width, log2(RRF_DEPTH)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all in-flight renames; rebuild free list
- map_en_A  in  1  slot A needs a destination tag this cycle
- map_en_B  in  1  slot B needs a destination tag this cycle
- tagA  out  TAG_W  tag granted to A (valid when map_en_A & !errorA)
- tagB  out  TAG_W  tag granted to B (valid when map_en_B & !errorB)
- errorA  out  1  A rename failed; hold A
- errorB  out  1  B rename failed; hold B
- free_en_A  in  1  retire slot A releases free_tag_A
- free_en_B  in  1  retire slot B releases free_tag_B
- free_tag_A  in  TAG_W  released tag
- free_tag_B  in  TAG_W  released tag
- ready  out  1  1 when in RUN state
- free_count  out  TAG_W+1  current number of free tags
- overflow_err  out  1  sticky: a free was pushed into a full list

## Operation
- Storage: circular FIFO `fl[RRF_DEPTH]` of TAG_W, head (pop) and tail (push) pointers TAG_W wide, plus count TAG_W+1 wide.
- States: INIT, RUN.
- INIT:
  - Writes fl[idx]=idx, idx = 0..RRF_DEPTH-1, one entry per cycle.
  - After the last write: head=0, tail=0, count=RRF_DEPTH, go to RUN.
  - In INIT, ready=0, errorA=map_en_A, errorB=map_en_B. Frees are ignored.
- RUN, grants (combinational from registered state):
  - A granted iff map_en_A & count≥1; tagA=fl[head].
  - B granted iff map_en_B & !errorA & count≥(map_en_A?2:1).
  - tagB=fl[head+map_en_A] (mod RRF_DEPTH).
  - Program order: if A errors, B errors too, even if a tag is free.
  - tagX is driven 0 when its slot is not granted.
- RUN, frees:
  - A free pushes at tail first, then B.
  - Pushes use only the tail, so same-cycle pops never conflict with them.
  - Frees are not bypassed to same-cycle allocations.
- Update: head += grants; tail += accepted frees; count += accepted frees − grants. Pointers wrap modulo RRF_DEPTH.
- Overflow: a free that would take count above RRF_DEPTH is dropped and sets overflow_err.
  - Evaluate A before B, after that cycle's pops.
  - overflow_err is cleared only by rst.
- flush: from any state, next state is INIT with idx=0. Same-cycle grants and frees are discarded.
  - In the flush cycle, errorA=map_en_A and errorB=map_en_B.
- Priority: rst > flush > normal operation.

## Timing
- Reset values (cycle after rst is sampled high):
  - state=INIT, idx=0, head=0, tail=0, count=0, free_count=0.
  - ready=0, overflow_err=0, tagA=tagB=0.
  - errorA=map_en_A, errorB=map_en_B.
- INIT lasts exactly RRF_DEPTH cycles. ready rises on cycle RRF_DEPTH after rst deasserts.
- Grant latency is 0 cycles: tags and errors are valid in the same cycle as map_en. Allocation commits at the next clock edge.
- A freed tag becomes allocatable 1 cycle after free_en.
- Empty list (count=0) with both slots requesting: errorA=errorB=1, no state change apart from frees.
- count=1 with both requesting: A granted, B errors.
- Full list with both frees: both dropped, overflow_err=1 next cycle.
- rst or flush mid-INIT: idx restarts at 0.

## Configuration
- RRF_STALL_CNT_EN
  - Defined: adds output stall_cnt (32 bits).
    - Counts RUN cycles with errorA | errorB, saturating at 0xFFFFFFFF.
    - Cleared by rst only; flush does not clear it.
  - Undefined: the port and counter do not exist. All other behaviour is identical.

## Test plan
- Reset init: rst 1 cycle, then idle.
  - ready=0 for 16 cycles, then 1, with free_count=16.
  - First dual request yields tagA=0, tagB=1.
- Exhaustion: dual requests for 8 cycles.
  - Tags 0..15 granted in order, free_count=0.
  - 9th cycle: errorA=errorB=1.
- Partial: free_count=1, map_en_A=map_en_B=1.
  - errorA=0, errorB=1, free_count=0 next cycle.
  - Then map_en_A=0, map_en_B=1 (free_count=0): errorB=1.
- Free/alloc same cycle at count=0: free_tag_A=5 with map_en_A=1.
  - errorA=1 that cycle.
  - Next cycle map_en_A=1 gives tagA=5.
- Wrap and overflow:
  - Allocate and free continuously for 40 cycles; verify FIFO order across wrap.
  - At count=16, free_en_A=1 → overflow_err=1 and stays 1.
- Flush mid-run:
  - Flush at count=3: next 16 cycles have ready=0 with errors on requests.
  - Then free_count=16 and tagA=0.
  - With RRF_STALL_CNT_EN, stall_cnt increments only in RUN stall cycles.

Source files
------------

// File: rtl/rrf_alloc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rrf_alloc_ctrl
// Purpose  : Free-list controller for the rename register file. Grants up to
//            two RRF tags per cycle to decode slots A/B and accepts up to two
//            retired tags per cycle. It rebuilds its own free list after
//            reset or flush, one entry per cycle.
// Ports    : clk, rst (sync, active-high), flush
//            map_en_A/B  -> tagA/B, errorA/B   (same-cycle grant)
//            free_en_A/B, free_tag_A/B         (retire returns)
//            ready, free_count, overflow_err (sticky)
//            stall_cnt (only when RRF_STALL_CNT_EN is defined)
// Options  : RRF_STALL_CNT_EN - adds a saturating 32-bit stall counter
// Revision : 1.0 - initial release
// ============================================================================
module rrf_alloc_ctrl #(
  parameter int RRF_DEPTH = 16,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             map_en_A,
  input  logic             map_en_B,
  output logic [TAG_W-1:0] tagA,
  output logic [TAG_W-1:0] tagB,
  output logic             errorA,
  output logic             errorB,
  input  logic             free_en_A,
  input  logic             free_en_B,
  input  logic [TAG_W-1:0] free_tag_A,
  input  logic [TAG_W-1:0] free_tag_B,
  output logic             ready,
  output logic [TAG_W:0]   free_count,
  output logic             overflow_err
`ifdef RRF_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [TAG_W:0]   c_DEPTH = (TAG_W+1)'(RRF_DEPTH);
  localparam logic [TAG_W-1:0] c_LAST  = TAG_W'(RRF_DEPTH - 1);

  state_t           r_state;
  logic [TAG_W-1:0] r_fl [RRF_DEPTH];
  logic [TAG_W-1:0] r_idx;
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;

  logic             w_active;
  logic [TAG_W:0]   w_need_b;
  logic             w_grant_a;
  logic             w_grant_b;
  logic [TAG_W-1:0] w_head_b;
  logic [1:0]       w_n_grant;
  logic [TAG_W:0]   w_cnt_pop;
  logic             w_acc_a;
  logic             w_acc_b;
  logic [1:0]       w_n_acc;
  logic [TAG_W-1:0] w_tail_b;
  logic             w_drop;

  // Grants are combinational from registered state; a flush cycle behaves
  // like INIT so nothing is handed out that the flush would discard.
  always_comb begin
    w_active  = (r_state == ST_RUN) && !flush;
    w_need_b  = map_en_A ? (TAG_W+1)'(2) : (TAG_W+1)'(1);
    w_grant_a = w_active && map_en_A && (r_count != '0);
    errorA    = map_en_A && !w_grant_a;
    // B never overtakes a stalled A (program order).
    w_grant_b = w_active && map_en_B && !errorA && (r_count >= w_need_b);
    errorB    = map_en_B && !w_grant_b;
    w_head_b  = r_head + TAG_W'(map_en_A);
    tagA      = w_grant_a ? r_fl[r_head]   : '0;
    tagB      = w_grant_b ? r_fl[w_head_b] : '0;
    w_n_grant = {1'b0, w_grant_a} + {1'b0, w_grant_b};
    // Overflow is judged after this cycle's pops, A before B.
    w_cnt_pop = r_count - (TAG_W+1)'(w_n_grant);
    w_acc_a   = w_active && free_en_A && (w_cnt_pop < c_DEPTH);
    w_acc_b   = w_active && free_en_B &&
                ((w_cnt_pop + (TAG_W+1)'(w_acc_a)) < c_DEPTH);
    w_n_acc   = {1'b0, w_acc_a} + {1'b0, w_acc_b};
    w_tail_b  = r_tail + TAG_W'(w_acc_a);
    w_drop    = w_active && ((free_en_A && !w_acc_a) || (free_en_B && !w_acc_b));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_INIT;
      r_idx        <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      ready        <= 1'b0;
      overflow_err <= 1'b0;
    end else if (flush) begin
      r_state <= ST_INIT;
      r_idx   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      ready   <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_fl[r_idx] <= r_idx;
          if (r_idx == c_LAST) begin
            r_state <= ST_RUN;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= c_DEPTH;
            ready   <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_RUN: begin
          // Pushes only touch the tail, so they never collide with pops.
          if (w_acc_a) r_fl[r_tail]   <= free_tag_A;
          if (w_acc_b) r_fl[w_tail_b] <= free_tag_B;
          r_head  <= r_head + TAG_W'(w_n_grant);
          r_tail  <= r_tail + TAG_W'(w_n_acc);
          r_count <= w_cnt_pop + (TAG_W+1)'(w_n_acc);
          if (w_drop) overflow_err <= 1'b1;
        end
        default: begin
          r_state <= ST_INIT;
          r_idx   <= '0;
        end
      endcase
    end
  end

  assign free_count = r_count;

`ifdef RRF_STALL_CNT_EN
  // Only RUN-state stalls count; flush leaves the history intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((r_state == ST_RUN) && (errorA || errorB) &&
                 (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rrf_alloc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rrf_alloc_ctrl
// Purpose  : Self-checking bench for rrf_alloc_ctrl. A queue-based model of
//            the free list predicts every output; directed scenarios are
//            followed by a randomized phase with occasional flush/reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rrf_alloc_ctrl;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       map_en_A = 1'b0, map_en_B = 1'b0;
  logic [3:0] tagA, tagB;
  logic       errorA, errorB;
  logic       free_en_A = 1'b0, free_en_B = 1'b0;
  logic [3:0] free_tag_A = '0, free_tag_B = '0;
  logic       ready;
  logic [4:0] free_count;
  logic       overflow_err;
`ifdef RRF_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  rrf_alloc_ctrl #(.RRF_DEPTH(16), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .map_en_A(map_en_A), .map_en_B(map_en_B),
    .tagA(tagA), .tagB(tagB), .errorA(errorA), .errorB(errorB),
    .free_en_A(free_en_A), .free_en_B(free_en_B),
    .free_tag_A(free_tag_A), .free_tag_B(free_tag_B),
    .ready(ready), .free_count(free_count), .overflow_err(overflow_err)
`ifdef RRF_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: the free list as an ordered queue of tags.
  int q[$];
  bit in_run;
  int init_cnt;
  bit ovf;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    in_run = 0;
    init_cnt = 0;
  endtask

  // One clock cycle: drive, check outputs before the edge, advance the model.
  task automatic step(input bit r, input bit f, input bit ma, input bit mb,
                      input bit fa, input bit fb, input int ta, input int tb);
    bit ea, eb, ga, gb;
    int xa, xb, n;
    @(negedge clk);
    rst = r; flush = f; map_en_A = ma; map_en_B = mb;
    free_en_A = fa; free_en_B = fb;
    free_tag_A = 4'(ta); free_tag_B = 4'(tb);
    #1;
    n = q.size();
    if (in_run && !f) begin
      ea = ma && (n < 1);
      eb = mb && (ea || (n < (ma ? 2 : 1)));
    end else begin
      ea = ma;
      eb = mb;
    end
    ga = ma && !ea;
    gb = mb && !eb;
    xa = ga ? q[0] : 0;
    xb = gb ? q[ma ? 1 : 0] : 0;
    chk("errorA", 32'(errorA), 32'(ea));
    chk("errorB", 32'(errorB), 32'(eb));
    chk("tagA", 32'(tagA), 32'(xa));
    chk("tagB", 32'(tagB), 32'(xb));
    chk("ready", 32'(ready), 32'(in_run));
    chk("free_count", 32'(free_count), 32'(in_run ? n : 0));
    chk("overflow_err", 32'(overflow_err), 32'(ovf));
    @(posedge clk);
    if (r) begin
      model_reset();
      ovf = 0;
    end else if (f) begin
      model_reset();
    end else if (!in_run) begin
      init_cnt++;
      if (init_cnt == DEPTH) begin
        for (int i = 0; i < DEPTH; i++) q.push_back(i);
        in_run = 1;
      end
    end else begin
      if (ga) void'(q.pop_front());
      if (gb) void'(q.pop_front());
      if (fa) begin
        if (q.size() < DEPTH) q.push_back(ta & 15); else ovf = 1;
      end
      if (fb) begin
        if (q.size() < DEPTH) q.push_back(tb & 15); else ovf = 1;
      end
    end
  endtask

  initial begin
    bit r, f;
    // Bring the DUT out of an unknown power-up state before checking.
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    model_reset();
    ovf = 0;

    // Reset init: 16 INIT cycles then RUN with a full list.
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 0, 0, 0, 0, 0);

    // Exhaustion: 8 dual requests, then both must error.
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0, 0);

    // Partial: one free tag, dual request; then lone B at empty.
    step(0, 0, 0, 0, 1, 0, 7, 0);
    step(0, 0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);

    // Free and allocate in the same cycle at count=0: no bypass.
    step(0, 0, 1, 0, 1, 0, 5, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);

    // Wrap: seed a few tags, then pop/push continuously.
    step(0, 0, 0, 0, 1, 1, 0, 1);
    step(0, 0, 0, 0, 1, 1, 2, 3);
    for (int i = 0; i < 40; i++) step(0, 0, 1, 0, 1, 0, (i * 5 + 1) % 16, 0);

    // Fill to full, then overflow with a single free; must stay sticky.
    while (q.size() < DEPTH)
      step(0, 0, 0, 0, 1, (q.size() <= DEPTH - 2), q.size(), q.size() + 9);
    step(0, 0, 0, 0, 1, 0, 3, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 4, 6);

    // Flush at count=3, then INIT with requests, then fresh list.
    while (q.size() > 3) step(0, 0, 1, (q.size() >= 5), 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 1, 9, 10);
    for (int i = 0; i < DEPTH; i++)
      step(0, 0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 0, 2, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);

    // Randomized phase with occasional flush and reset.
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 255) == 0);
      f = ($urandom_range(0, 63) == 0);
      step(r, f, $urandom_range(0, 1), $urandom_range(0, 1),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0),
           $urandom_range(0, 15), $urandom_range(0, 15));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
